// File: rtl/store_buffer_pkg.sv
// Shared types and default sizing for the store buffer between the datapath
// memory stage and the word-addressed data memory.
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 10;
  localparam int SB_PTR_W = $clog2(SB_DEPTH);
  localparam int SB_CNT_W = $clog2(SB_DEPTH + 1);

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [31:0]      data;
  } entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// CPU-side and memory-side bus of the store buffer. The buffer sits on the
// slave modport; the datapath/memory environment drives the master side.
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int AW = SB_AW
) ();

  logic          cpu_st;
  logic          cpu_ld;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          stall;
  logic          empty;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_din;
  logic          dm_we;
  logic [31:0]   dm_dout;

  modport master (
    output cpu_st, cpu_ld, cpu_addr, cpu_wdata, dm_dout,
    input  cpu_rdata, stall, empty, dm_addr, dm_din, dm_we
  );

  modport slave (
    input  cpu_st, cpu_ld, cpu_addr, cpu_wdata, dm_dout,
    output cpu_rdata, stall, empty, dm_addr, dm_din, dm_we
  );

endinterface

// File: rtl/store_buffer_match.sv
// Parallel address compare over the valid buffer entries; reports whether any
// pending store matches and the index of the youngest such entry.
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = SB_PTR_W,
  parameter int CNT_W = SB_CNT_W,
  parameter int AW    = SB_AW
) (
  input  entry_t [DEPTH-1:0] entries,
  input  logic [PTR_W-1:0]   wr_ptr,
  input  logic [CNT_W-1:0]   count,
  input  logic [AW-1:0]      addr,
  output logic               hit,
  output logic [PTR_W-1:0]   idx
);

  logic [PTR_W-1:0] slot;

  // Walk backward from the newest entry; the first valid match is the youngest.
  always_comb begin
    hit  = 1'b0;
    idx  = wr_ptr;
    slot = wr_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      slot = wr_ptr - PTR_W'(k + 1);
      if (!hit && (CNT_W'(k) < count) && (entries[slot].addr == addr)) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer top: queues CPU stores and retires them to data memory when
// the load port is idle. Define STORE_BUFFER_FORWARD_EN to forward on a hit.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW
) (
  input logic          Clk,
  input logic          Reset,
  store_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t [DEPTH-1:0] entries;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   hit_idx;
  logic [CNT_W-1:0]   count;
  logic               hit;
  logic               ld;
  logic               full;
  logic               enq;
  logic               drain;
  logic               st_stall;
  logic               ld_stall;
  entry_t             head;
  logic [AW-1:0]      head_addr;

  store_buffer_match #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W),
    .CNT_W(CNT_W),
    .AW   (AW)
  ) u_match (
    .entries(entries),
    .wr_ptr (wr_ptr),
    .count  (count),
    .addr   (bus.cpu_addr),
    .hit    (hit),
    .idx    (hit_idx)
  );

  // A request with both strobes is a store; the load strobe still holds the port.
  assign ld       = bus.cpu_ld & ~bus.cpu_st;
  assign full     = (count == CNT_W'(DEPTH));
  assign enq      = bus.cpu_st & ~full;
  assign st_stall = bus.cpu_st & full;

`ifdef STORE_BUFFER_FORWARD_EN
  assign ld_stall = 1'b0;
`else
  assign ld_stall = ld & hit;
`endif

  // Reset suppresses the write so discarded stores never reach memory.
  assign drain     = (count != '0) & (~bus.cpu_ld | ld_stall) & ~Reset;
  assign head      = entries[rd_ptr];
  assign head_addr = head.addr;

  assign bus.dm_we     = drain;
  assign bus.dm_addr   = drain ? head_addr : bus.cpu_addr;
  assign bus.dm_din    = head.data;
  assign bus.cpu_rdata = hit ? entries[hit_idx].data : bus.dm_dout;
  assign bus.stall     = st_stall | ld_stall;
  assign bus.empty     = (count == '0);

  // Pointers wrap naturally at DEPTH; entry payloads need no reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        entries[wr_ptr] <= '{addr: bus.cpu_addr, data: bus.cpu_wdata};
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (drain) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(enq) - CNT_W'(drain);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic
// compared each cycle against a queue-based model of pending stores.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 10;
  localparam int NADDR = 64;
`ifdef STORE_BUFFER_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } pend_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  store_buffer_if #(.AW(AW)) bus ();

  store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  logic [31:0] dmem    [1024];
  bit          written [1024];
  logic [31:0] refMem  [1024];
  pend_t       pend[$];

  int errors = 0;
  int checks = 0;
  logic        lastStall, lastWe, lastEmpty;
  logic [31:0] lastRdata, lastDin;
  logic [AW-1:0] lastAddr;

  function automatic logic [31:0] seedWord(input logic [AW-1:0] a);
    return {22'h2A5A5A, a};
  endfunction

  // Data memory: combinational read, write on the rising edge.
  assign bus.dm_dout = written[bus.dm_addr] ? dmem[bus.dm_addr] : seedWord(bus.dm_addr);

  always @(posedge Clk) begin
    if (bus.dm_we) begin
      dmem[bus.dm_addr]    <= bus.dm_din;
      written[bus.dm_addr] <= 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check against the model, then commit.
  task automatic applyStimulus(input logic st, input logic ld, input logic [AW-1:0] addr,
                               input logic [31:0] wdata, input logic rst);
    bit          mLd, full, hit, ldStall, stStall, drain;
    logic [31:0] fwd;
    bus.cpu_st    = st;
    bus.cpu_ld    = ld;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    Reset         = rst;
    #1;
    mLd  = ld && !st;
    full = (pend.size() == DEPTH);
    hit  = 1'b0;
    fwd  = '0;
    foreach (pend[i]) begin
      if (pend[i].addr == addr) begin
        hit = 1'b1;
        fwd = pend[i].data;
      end
    end
    stStall = st && full;
    ldStall = !FWD && mLd && hit;
    drain   = !rst && (pend.size() > 0) && (!ld || ldStall);
    if (rst) begin
      checkOutput("reset_we", bus.dm_we, 0);
    end else begin
      checkOutput("stall", bus.stall, stStall || ldStall);
      checkOutput("empty", bus.empty, pend.size() == 0);
      checkOutput("dm_we", bus.dm_we, drain);
      checkOutput("dm_addr", bus.dm_addr, drain ? pend[0].addr : addr);
      if (drain) checkOutput("dm_din", bus.dm_din, pend[0].data);
      if (mLd && !ldStall)
        checkOutput("cpu_rdata", bus.cpu_rdata, (FWD && hit) ? fwd : refMem[addr]);
    end
    lastStall = bus.stall;
    lastWe    = bus.dm_we;
    lastEmpty = bus.empty;
    lastRdata = bus.cpu_rdata;
    lastDin   = bus.dm_din;
    lastAddr  = bus.dm_addr;
    if (rst) begin
      pend.delete();
    end else begin
      if (drain) begin
        refMem[pend[0].addr] = pend[0].data;
        void'(pend.pop_front());
      end
      if (st && !full) pend.push_back('{addr: addr, data: wdata});
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, AW'(i), 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] d5;
    logic [31:0] obs;
    for (int a = 0; a < 1024; a++) refMem[a] = seedWord(AW'(a));
    bus.cpu_st = 1'b0; bus.cpu_ld = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;

    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    idle(1);
    checkOutput("reset_empty", lastEmpty, 1);
    checkOutput("reset_stall", lastStall, 0);
    checkOutput("reset_dm_we", lastWe, 0);

    $display("[TB] single store then drain");
    applyStimulus(1'b1, 1'b0, 10'h010, 32'hDEADBEEF, 1'b0);
    idle(1);
    checkOutput("drain_we", lastWe, 1);
    checkOutput("drain_addr", lastAddr, 32'h010);
    checkOutput("drain_din", lastDin, 32'hDEADBEEF);
    idle(1);
    checkOutput("drain_empty", lastEmpty, 1);

    $display("[TB] fill with loads held high");
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 1'b1, AW'(10'h011 + i), 32'h5000_0000 + i, 1'b0);
    checkOutput("full_stall", lastStall, 1);
    d5 = 32'h5000_0004;
    applyStimulus(1'b1, 1'b0, 10'h015, d5, 1'b0);
    checkOutput("full_stall_drain", lastStall, 1);
    checkOutput("full_drain_we", lastWe, 1);
    for (int t = 0; t < 4 && lastStall; t++) applyStimulus(1'b1, 1'b0, 10'h015, d5, 1'b0);
    checkOutput("full_accept", lastStall, 0);
    idle(6);

    $display("[TB] same-address stores then load");
    applyStimulus(1'b1, 1'b1, 10'h020, 32'd1, 1'b0);
    applyStimulus(1'b1, 1'b1, 10'h020, 32'd2, 1'b0);
    applyStimulus(1'b0, 1'b1, 10'h020, 32'd0, 1'b0);
    for (int t = 0; t < 6 && lastStall; t++) applyStimulus(1'b0, 1'b1, 10'h020, 32'd0, 1'b0);
    checkOutput("hit_stall_done", lastStall, 0);
    checkOutput("hit_rdata", lastRdata, 2);
    idle(3);

    $display("[TB] load miss with entries pending");
    applyStimulus(1'b1, 1'b1, 10'h030, 32'hA0A0_0030, 1'b0);
    applyStimulus(1'b1, 1'b1, 10'h031, 32'hA0A0_0031, 1'b0);
    applyStimulus(1'b0, 1'b1, 10'h035, 32'd0, 1'b0);
    checkOutput("miss_we", lastWe, 0);
    checkOutput("miss_rdata", lastRdata, seedWord(10'h035));
    applyStimulus(1'b0, 1'b0, 10'h000, 32'd0, 1'b0);
    checkOutput("miss_count_kept", lastEmpty, 0);
    idle(3);

    $display("[TB] wrap-around");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, AW'(10'h038 + (i % 3)), 32'hC000_0000 + i, 1'b0);
      idle(1);
    end

    $display("[TB] reset with pending stores");
    applyStimulus(1'b1, 1'b1, 10'h03C, 32'hBAD0_003C, 1'b0);
    applyStimulus(1'b1, 1'b1, 10'h03D, 32'hBAD0_003D, 1'b0);
    applyStimulus(1'b1, 1'b1, 10'h03E, 32'hBAD0_003E, 1'b0);
    applyStimulus(1'b0, 1'b0, 10'h000, 32'd0, 1'b1);
    idle(1);
    checkOutput("post_reset_empty", lastEmpty, 1);
    checkOutput("post_reset_we", lastWe, 0);
    idle(2);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 3) == 0, ($urandom % 3) == 0, AW'($urandom % 16),
                    $urandom, 1'b0);
    end
    idle(DEPTH + 2);

    for (int a = 0; a < NADDR; a++) begin
      obs = written[a] ? dmem[a] : seedWord(AW'(a));
      checkOutput($sformatf("mem_%0h", a), obs, refMem[a]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
